// File: rtl/cpu_ctrl_unit.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_unit
// Multi-cycle control sequencer for a small accumulator CPU. Each instruction
// walks FETCH -> DECODE -> EXEC (-> WRITE_BACK when WB_EN=1) and the unit
// produces the program-counter address, the decoded instruction fields and
// the accumulator / register-file write enables.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rstn       : asynchronous active-low reset
//   instr      : program-memory word {opcode[2:0], operand[REG_ADDR_W-1:0]}
//   stall      : hold request, freezes sequencing while high
//   acc_zero   : accumulator-equals-zero flag, used by JZ
//   pc_addr    : registered program counter
//   op_code    : opcode field of the instruction register
//   addr       : operand field of the instruction register
//   acc_ce     : accumulator write enable (LOAD/ADD/SUB write phase)
//   ce         : one-hot register-file write enables (STORE write phase)
//   halted     : high while in HALTED
//   curr_state : FETCH=000 DECODE=001 EXEC=010 WRITE_BACK=011 HALTED=100
// -----------------------------------------------------------------------------
module cpu_ctrl_unit #(
    parameter int  PC_W       = 5,
    parameter int  REG_ADDR_W = 2,
    parameter int  WB_EN      = 1,
    localparam int NUM_REGS   = 2 ** REG_ADDR_W,
    localparam int IW         = 3 + REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [IW-1:0]         instr,
    input  logic                  stall,
    input  logic                  acc_zero,
    output logic [PC_W-1:0]       pc_addr,
    output logic [2:0]            op_code,
    output logic [REG_ADDR_W-1:0] addr,
    output logic                  acc_ce,
    output logic [NUM_REGS-1:0]   ce,
    output logic                  halted,
    output logic [2:0]            curr_state
);

    localparam logic [2:0] ST_FETCH  = 3'b000;
    localparam logic [2:0] ST_DECODE = 3'b001;
    localparam logic [2:0] ST_EXEC   = 3'b010;
    localparam logic [2:0] ST_WB     = 3'b011;
    localparam logic [2:0] ST_HALTED = 3'b100;

    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_JZ    = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [PC_W-1:0]       r_pc;
    logic [IW-1:0]         r_ir;
    logic [2:0]            w_op;
    logic [REG_ADDR_W-1:0] w_opnd;
    logic                  w_wphase;
    logic                  w_pc_upd;
    logic                  w_take;
    logic [PC_W-1:0]       w_offset;

    assign w_op   = r_ir[IW-1 -: 3];
    assign w_opnd = r_ir[REG_ADDR_W-1:0];

    // The write phase is the last phase of a normal instruction.
    assign w_wphase = (WB_EN != 0) ? (r_state == ST_WB) : (r_state == ST_EXEC);

    // HALT never reaches a PC update, even when its EXEC is the write phase.
    assign w_pc_upd = w_wphase && !stall && (w_op != OP_HALT);
    assign w_take   = (w_op == OP_JMP) || ((w_op == OP_JZ) && acc_zero);
    assign w_offset = w_take ? PC_W'(w_opnd) : {PC_W{1'b0}};

    assign pc_addr    = r_pc;
    assign op_code    = w_op;
    assign addr       = w_opnd;
    assign curr_state = r_state;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Program counter and instruction register; both hold while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc <= {PC_W{1'b0}};
            r_ir <= {IW{1'b0}};
        end else begin
            if ((r_state == ST_FETCH) && !stall) begin
                r_ir <= instr;
            end
            if (w_pc_upd) begin
                // Natural PC_W-bit overflow gives the modulo wrap.
                r_pc <= r_pc + PC_W'(1'b1) + w_offset;
            end
        end
    end

    // Next-state logic; HALTED ignores stall, illegal codes recover to FETCH.
    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_FETCH: begin
                if (stall) w_next_state = ST_FETCH;
                else       w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (stall) w_next_state = ST_DECODE;
                else       w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (stall)                 w_next_state = ST_EXEC;
                else if (w_op == OP_HALT)  w_next_state = ST_HALTED;
                else if (WB_EN != 0)       w_next_state = ST_WB;
                else                       w_next_state = ST_FETCH;
            end
            ST_WB: begin
                if (stall) w_next_state = ST_WB;
                else       w_next_state = ST_FETCH;
            end
            ST_HALTED: w_next_state = ST_HALTED;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // Output decode: enables only in an unstalled write phase, so a stalled
    // write phase fires exactly once, in its first unstalled cycle.
    always_comb begin
        acc_ce = 1'b0;
        ce     = {NUM_REGS{1'b0}};
        halted = (r_state == ST_HALTED);
        if (w_wphase && !stall) begin
            case (w_op)
                OP_LOAD, OP_ADD, OP_SUB: acc_ce = 1'b1;
                OP_STORE: ce = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_opnd;
                default: begin
                    acc_ce = 1'b0;
                    ce     = {NUM_REGS{1'b0}};
                end
            endcase
        end else begin
            acc_ce = 1'b0;
            ce     = {NUM_REGS{1'b0}};
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl_unit
// Two instances share clock, reset, stall and acc_zero:
//   A: PC_W=5, WB_EN=1 (four-phase instructions)
//   B: PC_W=3, WB_EN=0 (three-phase instructions, writes in EXEC)
// Each instance fetches from its own program array indexed by its pc_addr.
// The reference model is an instruction interpreter: each instruction lasts a
// fixed number of unstalled cycles, the last one being the write phase.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, stall, acc_zero;
    logic [4:0] mem_a [32];
    logic [4:0] mem_b [8];
    logic [4:0] instr_a, instr_b;
    logic [4:0] pc_a;
    logic [2:0] pc_b;
    logic [2:0] op_a, op_b, st_a, st_b;
    logic [1:0] ad_a, ad_b;
    logic       acc_a, acc_b, h_a, h_b;
    logic [3:0] ce_a, ce_b;

    assign instr_a = mem_a[pc_a];
    assign instr_b = mem_b[pc_b];

    cpu_ctrl_unit #(.PC_W(5), .REG_ADDR_W(2), .WB_EN(1)) dut_a (
        .clk(clk), .rstn(rstn), .instr(instr_a), .stall(stall), .acc_zero(acc_zero),
        .pc_addr(pc_a), .op_code(op_a), .addr(ad_a), .acc_ce(acc_a), .ce(ce_a),
        .halted(h_a), .curr_state(st_a));

    cpu_ctrl_unit #(.PC_W(3), .REG_ADDR_W(2), .WB_EN(0)) dut_b (
        .clk(clk), .rstn(rstn), .instr(instr_b), .stall(stall), .acc_zero(acc_zero),
        .pc_addr(pc_b), .op_code(op_b), .addr(ad_b), .acc_ce(acc_b), .ce(ce_b),
        .halted(h_b), .curr_state(st_b));

    // Reference model state per instance (0 = A, 1 = B).
    int  m_pc [2];
    int  m_ph [2];     // cycles already spent in the current instruction
    int  m_op [2];
    int  m_ar [2];
    bit  m_halt [2];
    int  PWID [2] = '{5, 3};
    int  NPH  [2] = '{4, 3};   // cycles per instruction; last is the write phase
    string NM [2] = '{"A", "B"};

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = 0; m_ph[d] = 0; m_op[d] = 0; m_ar[d] = 0; m_halt[d] = 1'b0;
        end
    endtask

    // Advance the interpreter by one clock edge.
    task automatic model_step();
        logic [4:0] w;
        bit jmp;
        for (int d = 0; d < 2; d++) begin
            if (!m_halt[d] && !stall) begin
                if (m_ph[d] == 0) begin
                    w = (d == 1) ? mem_b[m_pc[1]] : mem_a[m_pc[0]];
                    m_op[d] = int'(w[4:2]);
                    m_ar[d] = int'(w[1:0]);
                end
                if (m_ph[d] == 2 && m_op[d] == 7) begin
                    m_halt[d] = 1'b1;
                end else if (m_ph[d] == NPH[d] - 1) begin
                    jmp = (m_op[d] == 5) || (m_op[d] == 6 && acc_zero);
                    m_pc[d] = (m_pc[d] + 1 + (jmp ? m_ar[d] : 0)) % (1 << PWID[d]);
                    m_ph[d] = 0;
                end else begin
                    m_ph[d] = m_ph[d] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        bit live;
        int e_acc, e_ce;
        for (int d = 0; d < 2; d++) begin
            live  = !m_halt[d] && (m_ph[d] == NPH[d] - 1) && !stall;
            e_acc = (live && (m_op[d] == 1 || m_op[d] == 3 || m_op[d] == 4)) ? 1 : 0;
            e_ce  = (live && m_op[d] == 2) ? (1 << m_ar[d]) : 0;
            chk({NM[d], "_state"},  (d == 1) ? st_b  : st_a,  m_halt[d] ? 4 : m_ph[d]);
            chk({NM[d], "_pc"},     (d == 1) ? pc_b  : pc_a,  m_pc[d]);
            chk({NM[d], "_opcode"}, (d == 1) ? op_b  : op_a,  m_op[d]);
            chk({NM[d], "_addr"},   (d == 1) ? ad_b  : ad_a,  m_ar[d]);
            chk({NM[d], "_acc_ce"}, (d == 1) ? acc_b : acc_a, e_acc);
            chk({NM[d], "_ce"},     (d == 1) ? ce_b  : ce_a,  e_ce);
            chk({NM[d], "_halted"}, (d == 1) ? h_b   : h_a,   m_halt[d] ? 1 : 0);
        end
    endtask

    // One clock: drive inputs, check mid-cycle, advance model at the edge.
    task automatic run_cycle(input bit s, input bit z);
        stall    = s;
        acc_zero = z;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic reset_pulse();
        rstn = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b1; stall = 1'b0; acc_zero = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = {3'($urandom_range(0, 6)), 2'($urandom_range(0, 3))};
        end
        mem_a[0] = 5'b001_01;   // LOAD R1
        mem_a[1] = 5'b010_10;   // STORE R2
        mem_a[2] = 5'b011_00;   // ADD R0
        // B loops 0 -> 1(JMP 2) -> 4(JZ 2) -> 7(NOP, wraps to 0) or 5(JMP 3, wraps to 1)
        for (int i = 0; i < 8; i++) mem_b[i] = 5'b000_01;
        mem_b[1] = 5'b101_10;
        mem_b[4] = 5'b110_10;
        mem_b[5] = 5'b101_11;
        mem_b[7] = 5'b000_00;

        #1 rstn = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 rstn = 1'b1;

        // LOAD / STORE unstalled, then a 3-cycle stall over ADD's EXEC.
        for (int i = 0; i < 30; i++) run_cycle(i >= 10 && i <= 12, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 600; i++)
            run_cycle($urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));

        // Force A into HALTED and hold it there under random stall.
        for (int i = 0; i < 32; i++) mem_a[i] = 5'b111_00;
        for (int i = 0; i < 60; i++)
            run_cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        reset_pulse();

        // Fully random programs, each run ended by a mid-instruction reset.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) mem_a[i] = 5'($urandom_range(0, 31));
            for (int i = 0; i < 8; i++)  mem_b[i] = 5'($urandom_range(0, 31));
            for (int i = 0; i < 100 + int'($urandom_range(0, 80)); i++)
                run_cycle($urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
            reset_pulse();
        end
        run_cycle(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
